// File: rtl/prco_fetch.sv
// prco instruction fetch stage: owns the PC, reads local memory combinationally and
// registers {instr, pc} for decode. Optional HALT-opcode stop under `PRCO_FETCH_HALT_EN.
module prco_fetch #(
  parameter logic [15:0] P_RESET_VECTOR = 16'h0000,
  parameter logic [15:0] P_PC_LIMIT     = 16'd255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic        i_p_cp,
  input  logic [15:0] i_jmp_addr,
  input  logic        i_p_stalled,
  output logic        q_p_stalled,
  output logic        q_p_valid,
  output logic        q_p_ce,
  output logic [15:0] q_mem_addr,
  input  logic [15:0] i_mem_douta,
  output logic [15:0] q_pc,
  output logic [15:0] q_instr,
  output logic [15:0] q_instr_pc
);

`ifdef PRCO_FETCH_HALT_EN
  typedef enum logic {S_RUN, S_HALT} state_t;
`else
  typedef enum logic {S_RUN} state_t;
`endif

  state_t state;

  always_comb begin
    q_p_stalled = q_p_valid && i_p_stalled;
    q_p_ce      = i_en && (state == S_RUN) && !q_p_stalled && !i_p_cp;
    q_mem_addr  = q_pc;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= S_RUN;
      q_pc       <= P_RESET_VECTOR;
      q_p_valid  <= 1'b0;
      q_instr    <= '0;
      q_instr_pc <= '0;
    end else if (i_p_cp) begin
      state     <= S_RUN;
      q_pc      <= i_jmp_addr;
      q_p_valid <= 1'b0;
    end else if (q_p_ce) begin
      q_instr    <= i_mem_douta;
      q_instr_pc <= q_pc;
      q_p_valid  <= 1'b1;
`ifdef PRCO_FETCH_HALT_EN
      // HALT word is still delivered, but the PC parks on it
      if (i_mem_douta[15:11] == 5'b11111)
        state <= S_HALT;
      else
        q_pc <= (q_pc == P_PC_LIMIT) ? '0 : q_pc + 16'd1;
`else
      q_pc <= (q_pc == P_PC_LIMIT) ? '0 : q_pc + 16'd1;
`endif
    end else if (!q_p_stalled) begin
      q_p_valid <= 1'b0;
    end
  end

endmodule

// File: doc/prco_fetch.md
Name: prco_fetch

Overview:
- Instruction fetch stage of the prco core; first stage of the pipeline, directly upstream of the decode stage.
- Owns the program counter and drives the local memory address port.
- Local memory read is combinational: data for the current address is valid in the same cycle.
- Latches the returned 16-bit instruction plus its PC into a pipeline register.
- Presents that register to the next stage with the core's valid/stalled/ce handshake.
- Accepts pipeline clear / jump redirects from downstream.

Parameters:
- P_RESET_VECTOR, 16'h0000, PC value loaded on reset.
- P_PC_LIMIT, 255, highest fetchable word address; PC wraps from P_PC_LIMIT to 0 (matches the local memory depth).

Ports:
- i_clk  input  1  core clock, all state on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_en  input  1  core run enable; fetch issues only while high.
- i_p_cp  input  1  pipeline clear (redirect) request from downstream.
- i_jmp_addr  input  16  new PC, sampled when i_p_cp=1.
- i_p_stalled  input  1  next stage is stalled.
- q_p_stalled  output  1  this stage is stalled.
- q_p_valid  output  1  q_instr/q_instr_pc hold a valid instruction.
- q_p_ce  output  1  fetch advances this cycle.
- q_mem_addr  output  16  address to local memory; always equals q_pc.
- i_mem_douta  input  16  combinational read data from local memory.
- q_pc  output  16  current program counter.
- q_instr  output  16  latched instruction.
- q_instr_pc  output  16  address the latched instruction was fetched from.

Behaviour:
- Reset (i_reset=1, highest priority):
  - q_pc=P_RESET_VECTOR; q_p_valid=0; q_instr=16'h0000; q_instr_pc=16'h0000.
  - State returns to S_RUN.
  - Reset asserted mid-stall or mid-redirect discards everything.
- States:
  - S_RUN: normal fetch.
  - S_HALT: exists only with the optional feature; otherwise the block has the single state S_RUN.
- Handshake (combinational):
  - q_p_stalled = q_p_valid && i_p_stalled.
  - q_p_ce = i_en && (state==S_RUN) && !q_p_stalled && !i_p_cp.
  - q_mem_addr = q_pc.
- Fetch: on q_p_ce
  - q_instr<=i_mem_douta; q_instr_pc<=q_pc; q_p_valid<=1.
  - q_pc <= (q_pc==P_PC_LIMIT) ? 0 : q_pc+1.
  - Latency: one instruction per cycle; instruction appears on q_instr one cycle after its address is driven.
- Stall (q_p_stalled=1, no i_p_cp): q_pc, q_instr, q_instr_pc, q_p_valid all hold; no instruction is lost or duplicated.
- Idle (i_en=0, not stalled, no i_p_cp): q_pc holds; q_p_valid<=0 (bubble).
- Redirect (i_p_cp=1, priority over stall and fetch):
  - q_pc<=i_jmp_addr; q_p_valid<=0; q_instr/q_instr_pc unchanged.
  - No fetch that cycle.
  - First fetch from the target occurs the next cycle, if enabled.
- Redirect to an address above P_PC_LIMIT is loaded as-is; the following increment still uses the ==P_PC_LIMIT wrap test, so increment is mod 2^16 outside range.
- Downstream sees valid drop for exactly one cycle per redirect when i_en stays high.

Optional Feature:
- Macro: PRCO_FETCH_HALT_EN.
- With it: when a fetched word has i_mem_douta[15:11]==5'b11111 (HALT):
  - The word is latched and passed downstream as normal.
  - q_pc does not increment.
  - State moves to S_HALT.
- In S_HALT:
  - q_p_ce=0; no further fetches.
  - q_p_valid clears once the next stage accepts (not stalled).
  - Leaves S_HALT only on i_reset, or on i_p_cp (load i_jmp_addr, return to S_RUN).
- Without it: opcode 5'b11111 is fetched like any other word; no S_HALT state.

Test Plan:
- Memory {0:16'h20ab, 1:16'h21cd, 2:16'h0000, 3:16'h22ef}, reset then i_en=1 -> q_instr 20ab,21cd,0000,22ef on 4 consecutive cycles; q_instr_pc 0,1,2,3; q_pc=4 after.
- Assert i_p_stalled for 3 cycles while q_instr=21cd -> q_instr=21cd, q_instr_pc=1, q_pc=2 held; next cycle after release q_instr=0000.
- i_p_cp=1, i_jmp_addr=3 while q_pc=1 -> next cycle q_p_valid=0, q_pc=3; following cycle q_instr=22ef, q_instr_pc=3.
- Redirect to 255 (P_PC_LIMIT) -> fetch at 255, then q_pc=0, next q_instr_pc=0.
- i_en toggled low for 2 cycles -> q_p_valid=0 both cycles, q_pc unchanged; resumes at same address.
- PRCO_FETCH_HALT_EN, mem[2]=16'hf800 -> q_instr=f800 valid once, q_pc stays 2, q_p_ce=0 thereafter; i_p_cp to 0 resumes fetch of 20ab.
